fr_prefix_adder_pipe: RTL
=========================

// Module: fr_prefix_adder_pipe
// PURPOSE
//  Parametrised, pipelined Kogge-Stone fraction adder/subtractor for the FP MAC datapath.
//  Generates G/P with a carry-in slot at bit 0, runs the prefix tree with configurable register spacing and forms the sum.
//  In subtract mode it returns the magnitude and corrects the sign; exact cancellation is flagged.
//  Sits between the alignment shifter and the normaliser; a valid/ready stream with stall propagation.
// PARAMETERS
//  WIDTH        24  fraction operand width (hidden bit included)
//  LVL_PER_REG  2   prefix levels between pipeline registers (1..NLVL)
//  Derived: NLVL = clog2(WIDTH+1); NPFX = ceil(NLVL/LVL_PER_REG); LAT = NPFX+2 (WIDTH=24, LVL_PER_REG=2 -> LAT=5)
// PORTS
//  clock      in   1        rising-edge clock
//  resetn     in   1        asynchronous, active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block accepts beat this cycle
//  in_a       in   WIDTH    operand A (aligned fraction)
//  in_b       in   WIDTH    operand B (aligned fraction)
//  in_sub     in   1        1: A-B, 0: A+B
//  in_sign    in   1        sign associated with A
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_sum    out  WIDTH+1  add: carry:sum; sub: {1'b0, |A-B|}
//  out_sign   out  1        result sign
//  out_zero   out  1        result is exactly zero
// BEHAVIOUR
//  - Reset (async, resetn=0): every pipeline register, including valid bits, clears to 0 -> out_valid=0, out_sum=0, out_sign=0, out_zero=0.
//    A beat in flight at reset is discarded; no partial result is emitted after release.
//  - Global enable: en = !out_valid | out_ready; in_ready = en (combinational); all stages advance only when en=1.
//  - Accept: in_valid & in_ready. Latency is exactly LAT cycles from accept to out_valid when never stalled; throughput 1/cycle.
//  - Stall: out_valid & !out_ready freezes every stage; out_* hold stable; no beat is dropped or duplicated; order is preserved.
//  - Bubbles (in_valid=0) propagate as valid=0 stages; data in bubble stages is don't-care.
//  - Stage 0 (prepare): Bx = in_sub ? ~in_b : in_b; G[WIDTH:1] = in_a & Bx; P[WIDTH:1] = in_a ^ Bx; G[0] = in_sub (carry-in); P[0] = 0.
//    Registers G, P (WIDTH+1 bits), P-copy for sum, sub and sign.
//  - Prefix stages: level k (span 2^k): G'[i] = G[i] | P[i]&G[i-2^k]; P'[i] = P[i]&P[i-2^k] for i >= 2^k, else pass-through.
//    Register after every LVL_PER_REG levels and after the last level.
//  - Final stage: s[i] = Pinit[i+1] ^ Gfinal[i], i = 0..WIDTH-1; cout = Gfinal[WIDTH].
//    * add: out_sum = {cout, s}; out_sign = sign; out_zero = (cout:s == 0).
//    * sub, cout=1 (A>=B): out_sum = {1'b0, s}; out_sign = sign.
//    * sub, cout=0 (A<B): out_sum = {1'b0, ~s + 1}; out_sign = ~sign.
//    * sub with s == 0 (A==B): out_zero = 1, out_sign = 0 (+0).
//  - Width rules: no overflow in add (carry captured in out_sum[WIDTH]); sub magnitude always < 2^WIDTH.
//  - Simultaneous accept and emit in the same cycle is legal and required for full throughput.
// STRUCTURE
//  - Shared package fr_adder_pkg: clog2 function; NLVL, NPFX, LAT helpers; stage-payload field widths.
//  - Sub-module fr_prefix_level #(WIDTH, SPAN): one combinational Kogge-Stone level.
//    Instantiated NLVL times via generate; the registers live in fr_prefix_adder_pipe.
//  - Valid pipeline is a LAT-bit shift register under the common enable.
// TESTING (WIDTH=24, LVL_PER_REG=2)
//  1. add 0x800000+0x800000, sign=1 -> after 5 cycles out_sum=0x1000000, sign=1, zero=0.
//  2. add 0xFFFFFF+0x000001 -> out_sum=0x1000000 (full carry ripple through all levels).
//  3. sub 0x800000-0x400000, sign=0 -> out_sum=0x0400000, sign=0. Swapped operands -> out_sum=0x0400000, sign=1.
//  4. sub 0x123456-0x123456, sign=1 -> out_sum=0, zero=1, sign=0.
//  5. 10 back-to-back random beats, out_ready low cycles 3-5 -> results match the model, in order, none lost;
//     in_ready=0 during stall; out_* stable.
//  6. resetn low for 1 cycle with 3 beats in flight -> out_valid=0 next edge; no stale beat emitted; next beat latency 5.
//  Plus a scoreboard reference model on random operands/modes/stalls; sweep LVL_PER_REG in {1,2,5} and WIDTH in {11,24,53}.

Source files
------------

// File: rtl/fr_adder_pkg.sv
// Shared sizing helpers for the pipelined Kogge-Stone fraction adder.
package fr_adder_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Width of the G/P vectors: one slot per fraction bit plus the carry-in slot.
  function automatic int unsigned gp_width(input int unsigned width);
    return width + 1;
  endfunction

  // Number of Kogge-Stone levels needed to span all G/P slots.
  function automatic int unsigned nlvl(input int unsigned width);
    return clog2(width + 1);
  endfunction

  // Number of prefix pipeline registers.
  function automatic int unsigned npfx(input int unsigned width, input int unsigned lvl_per_reg);
    return (nlvl(width) + lvl_per_reg - 1) / lvl_per_reg;
  endfunction

  // Accept-to-output latency: prepare stage, prefix stages, sum stage.
  function automatic int unsigned lat(input int unsigned width, input int unsigned lvl_per_reg);
    return npfx(width, lvl_per_reg) + 2;
  endfunction

endpackage

// File: rtl/fr_prefix_level.sv
// One combinational Kogge-Stone level over WIDTH+1 G/P slots.
module fr_prefix_level #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SPAN  = 1
) (
  input  logic [WIDTH:0] g_i,
  input  logic [WIDTH:0] p_i,
  output logic [WIDTH:0] g_o,
  output logic [WIDTH:0] p_o
);

  genvar i;
  // Combine each slot with the slot SPAN below it; low slots pass through.
  for (i = 0; i <= WIDTH; i++) begin : g_slot
    if (i >= SPAN) begin : g_comb
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      assign p_o[i] = p_i[i] & p_i[i-SPAN];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/fr_prefix_adder_pipe.sv
// Pipelined Kogge-Stone fraction adder/subtractor with magnitude/sign correction.
module fr_prefix_adder_pipe
  import fr_adder_pkg::*;
#(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned LVL_PER_REG = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_sign,
  output logic             out_zero
);

  localparam int unsigned GW   = gp_width(WIDTH);
  localparam int unsigned NLVL = nlvl(WIDTH);
  localparam int unsigned NPFX = npfx(WIDTH, LVL_PER_REG);
  localparam int unsigned LAT  = lat(WIDTH, LVL_PER_REG);

  logic             en_c;
  logic [WIDTH-1:0] bx_c;

  // Stage registers: index 0 is the prepare stage, 1..NPFX the prefix stages.
  logic [GW-1:0]    g_q    [NPFX+1];
  logic [GW-1:0]    g_n    [NPFX+1];
  logic [GW-1:0]    p_q    [NPFX];
  logic [GW-1:0]    p_n    [NPFX];
  logic [WIDTH-1:0] pi_q   [NPFX+1];
  logic [WIDTH-1:0] pi_n   [NPFX+1];
  logic             sub_q  [NPFX+1];
  logic             sub_n  [NPFX+1];
  logic             sign_q [NPFX+1];
  logic             sign_n [NPFX+1];

  logic [GW-1:0]    gl_i [NLVL];
  logic [GW-1:0]    pl_i [NLVL];
  logic [GW-1:0]    gl_o [NLVL];
  logic [GW-1:0]    pl_o [NLVL];

  logic [LAT-1:0]   vld_q;
  logic [WIDTH-1:0] s_c;
  logic             cout_c;
  logic [WIDTH:0]   sum_c;
  logic             sign_c;
  logic             zero_c;
  logic             unused_p_c;

  // Global stall: everything advances only when the output slot can move.
  assign out_valid = vld_q[LAT-1];
  assign en_c      = !out_valid || out_ready;
  assign in_ready  = en_c;

  // Prepare: invert B for subtraction and seed the carry-in slot.
  assign bx_c      = in_sub ? ~in_b : in_b;
  assign g_n[0]    = {in_a & bx_c, in_sub};
  assign p_n[0]    = {in_a ^ bx_c, 1'b0};
  assign pi_n[0]   = in_a ^ bx_c;
  assign sub_n[0]  = in_sub;
  assign sign_n[0] = in_sign;

  genvar k, s;
  // Prefix tree: each segment of LVL_PER_REG levels starts from a register.
  for (k = 0; k < NLVL; k++) begin : g_lvl
    if ((k % LVL_PER_REG) == 0) begin : g_from_reg
      assign gl_i[k] = g_q[k / LVL_PER_REG];
      assign pl_i[k] = p_q[k / LVL_PER_REG];
    end else begin : g_from_lvl
      assign gl_i[k] = gl_o[k-1];
      assign pl_i[k] = pl_o[k-1];
    end
    fr_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (32'(1) << k)
    ) u_level (
      .g_i (gl_i[k]),
      .p_i (pl_i[k]),
      .g_o (gl_o[k]),
      .p_o (pl_o[k])
    );
  end

  // Next-state of each prefix register; group-propagate is dropped after the last level.
  for (s = 1; s <= NPFX; s++) begin : g_stage
    localparam int unsigned LAST =
      (((s * LVL_PER_REG) < NLVL) ? (s * LVL_PER_REG) : NLVL) - 1;
    assign g_n[s]    = gl_o[LAST];
    assign pi_n[s]   = pi_q[s-1];
    assign sub_n[s]  = sub_q[s-1];
    assign sign_n[s] = sign_q[s-1];
    if (s < NPFX) begin : g_keep_p
      assign p_n[s] = pl_o[LAST];
    end
  end

  assign unused_p_c = ^pl_o[NLVL-1];

  // Datapath stage registers, all under the common enable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i <= NPFX; i++) begin
        g_q[i]    <= '0;
        pi_q[i]   <= '0;
        sub_q[i]  <= 1'b0;
        sign_q[i] <= 1'b0;
      end
      for (int unsigned i = 0; i < NPFX; i++) begin
        p_q[i] <= '0;
      end
    end else if (en_c) begin
      for (int unsigned i = 0; i <= NPFX; i++) begin
        g_q[i]    <= g_n[i];
        pi_q[i]   <= pi_n[i];
        sub_q[i]  <= sub_n[i];
        sign_q[i] <= sign_n[i];
      end
      for (int unsigned i = 0; i < NPFX; i++) begin
        p_q[i] <= p_n[i];
      end
    end
  end

  // Sum formation with subtract magnitude/sign correction and zero detect.
  always_comb begin
    s_c    = pi_q[NPFX] ^ g_q[NPFX][WIDTH-1:0];
    cout_c = g_q[NPFX][WIDTH];
    sum_c  = {cout_c, s_c};
    sign_c = sign_q[NPFX];
    zero_c = ({cout_c, s_c} == '0);
    if (sub_q[NPFX]) begin
      if (cout_c) begin
        sum_c  = {1'b0, s_c};
        zero_c = (s_c == '0);
        if (zero_c) sign_c = 1'b0;
      end else begin
        sum_c  = {1'b0, ~s_c + WIDTH'(1)};
        sign_c = ~sign_q[NPFX];
        zero_c = 1'b0;
      end
    end
  end

  // Output register and valid shift register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q    <= '0;
      out_sum  <= '0;
      out_sign <= 1'b0;
      out_zero <= 1'b0;
    end else if (en_c) begin
      vld_q    <= {vld_q[LAT-2:0], in_valid};
      out_sum  <= sum_c;
      out_sign <= sign_c;
      out_zero <= zero_c;
    end
  end

endmodule
